// File: rtl/uart_path_loader.sv
// uart_path_loader
//   Receives a path program over an 8N1 UART line and writes it into the
//   256x8 path RAM that the playback sequencer later steps through.
//   Frame format: SYNC_BYTE, LEN (1..255), LEN command bytes, XOR checksum
//   where checksum = LEN ^ cmd[0] ^ ... ^ cmd[LEN-1]. Command bytes are opaque.
//
// Ports
//   inputclock  system clock
//   rst         synchronous, active-high reset
//   rx          UART serial input (idle high, asynchronous)
//   wr_en       RAM write strobe, one-cycle pulse
//   wr_addr     RAM write address (held when wr_en=0)
//   wr_data     RAM write data (held when wr_en=0)
//   busy        frame in progress (accepted sync byte through checksum)
//   load_done   level: last frame completed with good checksum
//   load_err    level: last frame aborted
//   cmd_count   commands written by the last good frame
//
// Handshake: the internal receiver-to-parser link is a one-cycle byte_valid
// pulse with the byte held stable on rx_byte; the parser has no back-pressure
// and consumes every pulse in the cycle it appears.
module uart_path_loader #(
    parameter int         CLK_HZ       = 50000000,
    parameter int         BAUD         = 9600,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic       inputclock,
    input  logic       rst,
    input  logic       rx,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       load_done,
    output logic       load_err,
    output logic [7:0] cmd_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TO_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM} fr_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer plus one extra flop for falling-edge detection.
    // All reset to 1 so reset release never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge inputclock) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             start_det;

    assign start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (start_det) rx_state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit sample; a high level here was only a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    bit_d    = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    shift_d  = {rx_sync_q, shift_q[7:1]};
                    bit_d    = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of
                // margin to catch a back-to-back start edge.
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid_d = 1'b1;
                    else           frame_err_d  = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge inputclock) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout: counts idle line time inside a frame.
    // ------------------------------------------------------------------
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout;
    logic            busy_q;

    assign timeout = busy_q && (rx_state_q == RX_IDLE) && !start_det
                     && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!busy_q || start_det)         to_cnt_d = '0;
        else if (rx_state_q == RX_IDLE && to_cnt_q != TO_LAST)
                                          to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge inputclock) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end

    // ------------------------------------------------------------------
    // Frame parser FSM
    // ------------------------------------------------------------------
    fr_state_t  fr_state_q, fr_state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic       busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] cmd_count_q, cmd_count_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       abort;

    assign abort = busy_q && (frame_err_q || timeout);

    always_comb begin
        fr_state_d  = fr_state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        cmd_count_d = cmd_count_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (fr_state_q)
            WAIT_SYNC: begin
                if (byte_valid_q && shift_q == SYNC_BYTE) begin
                    fr_state_d = GET_LEN;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 8'd0;
                    csum_d     = 8'd0;
                end
            end
            GET_LEN: begin
                if (byte_valid_q) begin
                    if (shift_q == 8'd0) begin
                        fr_state_d = WAIT_SYNC;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        len_d      = shift_q;
                        csum_d     = shift_q;
                        fr_state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (byte_valid_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = shift_q;
                    csum_d    = csum_q ^ shift_q;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) fr_state_d = GET_CSUM;
                end
            end
            GET_CSUM: begin
                if (byte_valid_q) begin
                    fr_state_d = WAIT_SYNC;
                    busy_d     = 1'b0;
                    if (shift_q == csum_q) begin
                        done_d      = 1'b1;
                        cmd_count_d = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: fr_state_d = WAIT_SYNC;
        endcase

        // Line-level faults override whatever the parser decided this cycle.
        if (abort) begin
            fr_state_d = WAIT_SYNC;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b1;
            wr_en_d    = 1'b0;
        end
    end

    always_ff @(posedge inputclock) begin
        if (rst) begin
            fr_state_q  <= WAIT_SYNC;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            csum_q      <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_count_q <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
        end else begin
            fr_state_q  <= fr_state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_count_q <= cmd_count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_uart_path_loader.sv
module tb_uart_path_loader;

    localparam int CPB = 16;  // 1600 Hz / 100 baud

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       load_done;
    logic       load_err;
    logic [7:0] cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];  // {addr, data} of each expected RAM write

    uart_path_loader #(
        .CLK_HZ(1600),
        .BAUD(100),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_BITS(20)
    ) dut (
        .inputclock(clk),
        .rst(rst),
        .rx(rx),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .load_done(load_done),
        .load_err(load_err),
        .cmd_count(cmd_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                         wr_addr, wr_data, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h (t=%0t)",
                             wr_addr, wr_data, e[15:8], e[7:0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    // sends a command byte and registers its expected RAM write
    task automatic send_cmd(input logic [7:0] addr, input logic [7:0] b);
        exp_q.push_back({addr, b});
        send(b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample_wait();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        sample_wait();
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);

        // good frame: csum = 03^11^22^33 = 03
        send(8'hA5);
        sample_wait();
        check("t1_busy_after_sync", busy, 1);
        send(8'h03);
        send_cmd(8'd0, 8'h11);
        send_cmd(8'd1, 8'h22);
        send_cmd(8'd2, 8'h33);
        send(8'h03);
        idle(5);
        sample_wait();
        check("t1_done", load_done, 1);
        check("t1_cmd_count", cmd_count, 3);
        check("t1_busy", busy, 0);
        check("t1_err", load_err, 0);
        check("t1_writes_seen", exp_q.size(), 0);

        // bad checksum
        idle(20);
        send(8'hA5);
        send(8'h03);
        send_cmd(8'd0, 8'h11);
        send_cmd(8'd1, 8'h22);
        send_cmd(8'd2, 8'h33);
        send(8'h04);
        idle(5);
        sample_wait();
        check("t2_err", load_err, 1);
        check("t2_done", load_done, 0);
        check("t2_cmd_count", cmd_count, 3);
        check("t2_busy", busy, 0);

        // noise in WAIT_SYNC plus a short glitch (false start)
        idle(20);
        send(8'h00);
        send(8'hFF);
        send(8'hA4);
        idle(10);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(40);
        sample_wait();
        check("t3_busy", busy, 0);
        check("t3_err_kept", load_err, 1);
        check("t3_done", load_done, 0);

        // timeout after one command of a len=2 frame
        send(8'hA5);
        send(8'h02);
        send_cmd(8'd0, 8'h11);
        idle(250);
        sample_wait();
        check("t4_busy_before_to", busy, 1);
        check("t4_err_before_to", load_err, 0);
        waited = 0;
        while (load_err !== 1'b1 && waited < 150) begin
            @(negedge clk);
            waited++;
        end
        check("t4_timeout_err", load_err, 1);
        check("t4_busy_after_to", busy, 0);
        check("t4_cmd_count", cmd_count, 3);

        // framing error inside a frame, then a good frame
        idle(100);
        send(8'hA5);
        send(8'h02);
        send_byte(8'h11, 1'b0);
        idle(32);
        sample_wait();
        check("t5_framing_err", load_err, 1);
        check("t5_busy", busy, 0);
        send(8'hA5);
        sample_wait();
        check("t5_err_cleared", load_err, 0);
        check("t5_busy_sync", busy, 1);
        send(8'h01);
        send_cmd(8'd0, 8'h5A);
        send(8'h5B);
        idle(5);
        sample_wait();
        check("t5_done", load_done, 1);
        check("t5_cmd_count", cmd_count, 1);
        check("t5_err", load_err, 0);

        // reset during the 2nd command of a len=4 frame
        idle(20);
        send(8'hA5);
        send(8'h04);
        send_cmd(8'd0, 8'h11);
        fork
            send(8'h22);
            begin
                repeat (40) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                sample_wait();
                check("t6_wr_en", wr_en, 0);
                check("t6_busy", busy, 0);
                check("t6_done", load_done, 0);
                check("t6_err", load_err, 0);
                check("t6_cmd_count", cmd_count, 0);
                check("t6_wr_addr", wr_addr, 0);
                check("t6_wr_data", wr_data, 0);
            end
        join
        idle(40 * CPB);
        sample_wait();
        check("t6_busy_idle", busy, 0);

        // fresh frame: csum = 02^66^77 = 13
        send(8'hA5);
        send(8'h02);
        send_cmd(8'd0, 8'h66);
        send_cmd(8'd1, 8'h77);
        send(8'h13);
        idle(5);
        sample_wait();
        check("t7_done", load_done, 1);
        check("t7_cmd_count", cmd_count, 2);
        check("t7_err", load_err, 0);

        idle(20);
        check("all_writes_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // absolute time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
